// File: rtl/fp_adder_scheduler_pkg.sv
// Shared float type, scheduler state encoding and constants for the
// single-adder round-robin scheduler.
package floatingpoint;
  typedef logic [31:0] float;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sched_state_t;

  localparam float FLOAT_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp_adder_scheduler_if.sv
// Bundles the requester handshakes and the shared-adder port of the scheduler.
// master = scheduler side, slave = clients plus adder side.
interface fp_adder_scheduler_if
  import floatingpoint::*;
#(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] ReqValid;
  logic [NUM_REQ-1:0] ReqReady;
  float [NUM_REQ-1:0] ReqOp1;
  float [NUM_REQ-1:0] ReqOp2;
  logic [NUM_REQ-1:0] RspValid;
  logic [NUM_REQ-1:0] RspReady;
  float               RspResult;
  logic               RspError;
  float               AddOp1;
  float               AddOp2;
  logic               AddInputValid;
  float               AddResult;
  logic               AddResultValid;

  modport master (
    input  ReqValid, ReqOp1, ReqOp2, RspReady, AddResult, AddResultValid,
    output ReqReady, RspValid, RspResult, RspError, AddOp1, AddOp2, AddInputValid
  );

  modport slave (
    output ReqValid, ReqOp1, ReqOp2, RspReady, AddResult, AddResultValid,
    input  ReqReady, RspValid, RspResult, RspError, AddOp1, AddOp2, AddInputValid
  );
endinterface

// File: rtl/fp_adder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping around, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any   = 1'b1;
        o_idx   = IDX_W'(w_pos);
        o_grant = NUM_REQ'(1) << w_pos;
      end
    end
  end
endmodule

// File: rtl/fp_adder_scheduler.sv
// Shares one FloatAdder among NUM_REQ requesters: round-robin accept, one
// start pulse, wait for the result or a timeout, route the answer back.
module fp_adder_scheduler
  import floatingpoint::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  fp_adder_scheduler_if.master io_bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_wait_cnt;
  float               r_op1;
  float               r_op2;
  float               r_result;
  logic               r_err;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic               w_timeout;
  logic               w_rsp_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (io_bus.ReqValid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  assign io_bus.AddOp1    = r_op1;
  assign io_bus.AddOp2    = r_op2;
  assign io_bus.RspResult = r_result;

  always_comb begin
    w_next               = r_state;
    io_bus.ReqReady      = '0;
    io_bus.RspValid      = '0;
    io_bus.RspError      = 1'b0;
    io_bus.AddInputValid = 1'b0;
    w_rsp_hs             = 1'b0;
    w_timeout            = (r_wait_cnt == CNT_LAST);
    unique case (r_state)
      IDLE: begin
        io_bus.ReqReady = w_grant;
        if (w_grant_any) w_next = ISSUE;
      end
      ISSUE: begin
        io_bus.AddInputValid = 1'b1;
        w_next               = WAIT;
      end
      WAIT: begin
        if (io_bus.AddResultValid || w_timeout) w_next = RESPOND;
      end
      RESPOND: begin
        io_bus.RspValid[r_owner] = 1'b1;
        io_bus.RspError          = r_err;
        if (io_bus.RspReady[r_owner]) begin
          w_rsp_hs = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands stay in r_op* from the grant until the next grant, so the adder
  // sees them unchanged for the whole ISSUE/WAIT window.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_wait_cnt <= '0;
      r_op1      <= FLOAT_ZERO;
      r_op2      <= FLOAT_ZERO;
      r_result   <= FLOAT_ZERO;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_op1   <= io_bus.ReqOp1[w_grant_idx];
            r_op2   <= io_bus.ReqOp2[w_grant_idx];
            r_owner <= w_grant_idx;
          end
        end
        ISSUE: r_wait_cnt <= '0;
        WAIT: begin
          if (r_wait_cnt != CNT_SAT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          // A result arriving on the last allowed cycle beats the timeout.
          if (io_bus.AddResultValid) begin
            r_result <= io_bus.AddResult;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= FLOAT_ZERO;
            r_err    <= 1'b1;
          end
        end
        RESPOND: begin
          if (w_rsp_hs) r_rr_ptr <= (r_owner == IDX_LAST) ? '0 : r_owner + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fp_adder_scheduler.md
# fp_adder_scheduler

Round-robin scheduler that shares one `FloatAdder` among `NUM_REQ` requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and issues it to the adder as a single-cycle `InputValid` pulse, holding the operands stable until the adder answers. It then returns the sum, or a timeout error, to the owning requester. It sits between the client datapaths and the single adder instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 16: maximum number of WAIT cycles without `AddResultValid` before an error response; must be ≥ 8.

Ports:
- Clock and reset: one clock, `Clock`; reset is asynchronous and active-low, port name `Reset`.
- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous active-low reset.
- `ReqValid`  in  NUM_REQ  per-requester request valid.
- `ReqReady`  out  NUM_REQ  per-requester accept; at most one bit high.
- `ReqOp1`, `ReqOp2`  in  NUM_REQ × float  per-requester operands.
- `RspValid`  out  NUM_REQ  per-requester response valid; at most one bit high.
- `RspReady`  in  NUM_REQ  per-requester response accept.
- `RspResult`  out  float  shared result bus; meaningful only with a `RspValid` bit.
- `RspError`  out  1  high with `RspValid` when the adder timed out.
- `AddOp1`, `AddOp2`  out  float  adder operands.
- `AddInputValid`  out  1  adder start pulse.
- `AddResult`  in  float  adder result.
- `AddResultValid`  in  1  adder completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - Grant goes to the first `ReqValid` bit at or after `RrPtr`, searching upward with wrap-around.
  - `ReqReady[grant]` is driven high combinationally in the same cycle.
  - On the handshake: capture `ReqOp1`/`ReqOp2` into the operand registers, record `Owner`, go to ISSUE.
  - `ReqReady` is all zero in every other state.
- **ISSUE** (1 cycle): `AddInputValid`=1, clear `WaitCnt`, go to WAIT.
- **WAIT**
  - `AddInputValid`=0; `WaitCnt` increments every cycle.
  - `AddResultValid`=1: capture `AddResult`, `ErrFlag`=0, go to RESPOND.
  - Otherwise, when `WaitCnt` reaches `TIMEOUT-1`: result register=0, `ErrFlag`=1, go to RESPOND.
  - If both conditions hold in the same cycle, `AddResultValid` wins.
- **RESPOND**
  - `RspValid[Owner]`=1; `RspResult` and `RspError` come from registers and are held stable until `RspReady[Owner]`.
  - On the handshake: `RrPtr` = (`Owner`+1) mod `NUM_REQ`, go to IDLE.
- `AddOp1`/`AddOp2` hold the captured operands from ISSUE through the end of WAIT, since the adder samples them over several cycles.
- `AddResultValid` is ignored outside WAIT. This covers late pulses after a timeout.
- `RspReady` bits of non-owners are ignored. `ReqValid` may drop before a grant with no side effect.

## Timing
- All outputs are zero at reset: `ReqReady`, `RspValid`, `RspResult`, `RspError`, `AddOp1`, `AddOp2`, `AddInputValid`.
- Reset values of internal state: FSM=IDLE, `RrPtr`=0, `WaitCnt`=0.
- Reset asserted mid-operation aborts the transaction with no response. The adder must be reset alongside.
- Latency, with the request accepted at cycle T:
  - `AddInputValid` is high in T+1.
  - If `AddResultValid` is sampled at cycle T+1+L, `RspValid` is high from T+2+L.
  - With the 5-cycle adder, a request accepted at T=0 gives `RspValid` at cycle 7.
- Timeout: `RspValid` with `RspError` in cycle T+2+`TIMEOUT`.
- Throughput: one transaction in flight at a time. The next grant is earliest the cycle after the `RspValid`/`RspReady` handshake.
- `WaitCnt` width is $clog2(`TIMEOUT`+1). It saturates and never wraps.

## Structure
- Package `floatingpoint`: reuses `float`. Add `sched_state_t` (the enum) and the constant `FLOAT_ZERO`.
- One natural sub-module, `rr_arbiter`: purely combinational. Takes the request vector and `RrPtr`, returns a one-hot grant and its index.
- FSM, operand/result registers and the timeout counter live in `fp_adder_scheduler`.

## Test plan
- Single request: requester 2 sends 1.0 (0x3F800000) + 2.0 (0x40000000) → one `AddInputValid` pulse; `RspValid[2]` with `RspResult`=0x40400000, `RspError`=0; `RrPtr`=3 afterwards.
- Fairness: all four `ReqValid` held high for 8 transactions, starting with `RrPtr`=0 → grant order 0,1,2,3,0,1,2,3. No requester is granted twice in a row while others are pending.
- Response backpressure: `RspReady[0]` held low for 10 cycles → `RspValid[0]`, `RspResult` and `RspError` stay constant; no new grant until the handshake.
- Timeout: the adder model never asserts `AddResultValid` → `RspValid` with `RspError`=1 and `RspResult`=0 at T+2+16. A late `AddResultValid` pulse afterwards causes no response.
- Operand hold: check that `AddOp1`/`AddOp2` are unchanged on every cycle from ISSUE through WAIT while `ReqOp*` inputs toggle randomly. Also check a mid-WAIT `Reset` low → all outputs read 0 in the same cycle; FSM=IDLE.
- Boundary: a result that arrives in the same cycle `WaitCnt` reaches `TIMEOUT-1` → normal response, `RspError`=0.
